immediate_gen: RTL and testbench
================================

IMMEDIATE_GEN -- requirements
Module: immediate_generator

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  qualifies ctrl/imm26 for capture this cycle.
REQ-005 ctrl  input  3  immediate format select.
REQ-006 imm26  input  26  instruction bits [25:0].
REQ-007 out_valid  output  1  imm64/illegal hold a result captured the previous cycle.
REQ-008 imm64  output  64  registered extended immediate.
REQ-009 illegal  output  1  registered flag: captured ctrl was unsupported.

Function
REQ-010 Format mapping SHALL be:
- 000 I: zero-extend imm26[21:10] (12 b).
- 001 D: sign-extend imm26[20:12] (9 b).
- 010 B: sign-extend imm26[25:0] (26 b).
- 011 CB: sign-extend imm26[23:5] (19 b).
- 100 LW: sign-extend imm26[20:5] (16 b).
REQ-011 ctrl 101/110/111 SHALL produce imm64=0 and illegal=1; legal codes SHALL produce illegal=0.
REQ-012 Sign-extension SHALL replicate the field MSB into every bit above the field, up to bit 63.
REQ-013 Bits of imm26 outside the selected field SHALL have no effect on imm64.
REQ-014 On a rising clk edge with in_valid=1, imm64 and illegal SHALL load the function of the current ctrl/imm26, and out_valid SHALL become 1.
- Latency: one cycle.
REQ-015 On a rising clk edge with in_valid=0, out_valid SHALL become 0, and imm64/illegal SHALL hold their values.
REQ-016 No backpressure SHALL exist: a new in_valid=1 input is accepted every cycle, and the result overwrites the previous one unconditionally.
REQ-017 The decode path from ctrl/imm26 to the register inputs SHALL be purely combinational, with no internal state other than the output registers.

Reset
REQ-018 rst_n low SHALL immediately, without waiting for clk, force imm64=0, out_valid=0 and illegal=0.
REQ-019 While rst_n is low, in_valid SHALL be ignored.
REQ-020 The first capture SHALL occur on the first rising clk edge with rst_n high.
REQ-021 Reset asserted mid-stream SHALL discard the pending result.

Configuration
REQ-022 Macro IMMGEN_BRSHIFT_EN, when defined, SHALL shift the sign-extended B and CB results left by 2 (word-to-byte offset).
- Bits shifted out above bit 63 are discarded.
- Zeros enter bits [1:0].
REQ-023 When IMMGEN_BRSHIFT_EN is not defined, B and CB results SHALL be unshifted.
REQ-024 I, D and LW results SHALL be identical whether or not IMMGEN_BRSHIFT_EN is defined.

Structure
REQ-025 A shared package SHALL hold:
- the ctrl encodings (FMT_I=0, FMT_D=1, FMT_B=2, FMT_CB=3, FMT_LW=4);
- the field MSB/LSB constants for each format;
- the output width constant 64.
REQ-026 A single sub-module, imm_sext, SHALL perform field extraction and extension.
- It is parameterized by field MSB, field LSB and a signed/unsigned flag.
- It is instantiated once per format; the top level muxes the results by ctrl.

Verification
REQ-027 Reset, then in_valid=1, ctrl=000, imm26=26'h000AAAA -> next cycle out_valid=1, imm64=64'h2A, illegal=0.
REQ-028 ctrl=001, imm26=26'h0101000 -> imm64=64'hFFFF_FFFF_FFFF_FF01; then ctrl=100, imm26=26'h0100020 -> imm64=64'hFFFF_FFFF_FFFF_8001.
REQ-029 ctrl=010, imm26=26'h3800015 -> imm64=64'hFFFF_FFFF_FF80_0015 without the macro, 64'hFFFF_FFFF_FE00_0054 with IMMGEN_BRSHIFT_EN.
REQ-030 ctrl=011, imm26=26'h1800038 -> imm64=64'hFFFF_FFFF_FFFC_0001 without the macro, 64'hFFFF_FFFF_FFF0_0004 with IMMGEN_BRSHIFT_EN.
REQ-031 ctrl=101, any imm26 -> imm64=0, illegal=1; then in_valid=0 -> out_valid=0, imm64 and illegal held.
REQ-032 Assert rst_n low between clk edges while out_valid=1 -> outputs clear at once; back-to-back in_valid=1 over 5 cycles -> each result appears exactly one cycle after its input.

Source files
------------

// File: rtl/immediate_gen_pkg.sv
// Shared constants and types for the immediate generator.
// Format encodings, per-format field bounds and the output width.
package immediate_gen_pkg;

    localparam int IMM_W = 64;
    localparam int IN_W  = 26;

    typedef enum logic [2:0] {
        FMT_I  = 3'd0,
        FMT_D  = 3'd1,
        FMT_B  = 3'd2,
        FMT_CB = 3'd3,
        FMT_LW = 3'd4
    } fmt_e;

    localparam int I_MSB  = 21;
    localparam int I_LSB  = 10;
    localparam int D_MSB  = 20;
    localparam int D_LSB  = 12;
    localparam int B_MSB  = 25;
    localparam int B_LSB  = 0;
    localparam int CB_MSB = 23;
    localparam int CB_LSB = 5;
    localparam int LW_MSB = 20;
    localparam int LW_LSB = 5;

    typedef struct packed {
        logic [IMM_W-1:0] imm64;
        logic             illegal;
    } imm_rsp_t;

endpackage

// File: rtl/immediate_gen_imm_sext.sv
// Extracts imm[MSB:LSB] and zero- or sign-extends it to IMM_W bits.
module imm_sext
    import immediate_gen_pkg::*;
#(
    parameter int MSB    = 11,
    parameter int LSB    = 0,
    parameter bit SIGNED = 1'b1
) (
    input  logic [IN_W-1:0]  imm,
    output logic [IMM_W-1:0] ext
);
    localparam int FW = MSB - LSB + 1;

    logic [FW-1:0] fld;
    assign fld = imm[MSB:LSB];

    generate
        if (SIGNED) begin : g_sext
            assign ext = {{(IMM_W-FW){fld[FW-1]}}, fld};
        end else begin : g_zext
            assign ext = {{(IMM_W-FW){1'b0}}, fld};
        end
    endgenerate
endmodule

// File: rtl/immediate_gen.sv
// One-cycle registered immediate decoder; IMMGEN_BRSHIFT_EN scales B/CB
// results from word to byte offsets.
module immediate_gen
    import immediate_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [2:0]        ctrl,
    input  logic [IN_W-1:0]   imm26,
    output logic              out_valid,
    output logic [IMM_W-1:0]  imm64,
    output logic              illegal
);
    logic [IMM_W-1:0] ext_i, ext_d, ext_b, ext_cb, ext_lw;
    logic [IMM_W-1:0] br_b, br_cb;
    imm_rsp_t         rsp_d;

    imm_sext #(.MSB(I_MSB),  .LSB(I_LSB),  .SIGNED(1'b0)) u_i  (.imm(imm26), .ext(ext_i));
    imm_sext #(.MSB(D_MSB),  .LSB(D_LSB),  .SIGNED(1'b1)) u_d  (.imm(imm26), .ext(ext_d));
    imm_sext #(.MSB(B_MSB),  .LSB(B_LSB),  .SIGNED(1'b1)) u_b  (.imm(imm26), .ext(ext_b));
    imm_sext #(.MSB(CB_MSB), .LSB(CB_LSB), .SIGNED(1'b1)) u_cb (.imm(imm26), .ext(ext_cb));
    imm_sext #(.MSB(LW_MSB), .LSB(LW_LSB), .SIGNED(1'b1)) u_lw (.imm(imm26), .ext(ext_lw));

`ifdef IMMGEN_BRSHIFT_EN
    assign br_b  = {ext_b[IMM_W-3:0],  2'b00};
    assign br_cb = {ext_cb[IMM_W-3:0], 2'b00};
`else
    assign br_b  = ext_b;
    assign br_cb = ext_cb;
`endif

    always_comb begin
        rsp_d = '{imm64: '0, illegal: 1'b0};
        case (ctrl)
            FMT_I:   rsp_d.imm64 = ext_i;
            FMT_D:   rsp_d.imm64 = ext_d;
            FMT_B:   rsp_d.imm64 = br_b;
            FMT_CB:  rsp_d.imm64 = br_cb;
            FMT_LW:  rsp_d.imm64 = ext_lw;
            default: rsp_d.illegal = 1'b1;
        endcase
    end

    // Payload holds when in_valid is low; only the valid bit drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            imm64     <= '0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                imm64   <= rsp_d.imm64;
                illegal <= rsp_d.illegal;
            end
        end
    end
endmodule

// File: tb/tb_immediate_gen.sv
// Directed checks of immediate_gen: formats, illegal codes, hold, reset, streaming.
module tb_immediate_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  ctrl = 3'd0;
    logic [25:0] imm26 = '0;
    logic        out_valid;
    logic [63:0] imm64;
    logic        illegal;

    int n_chk = 0;
    int n_fail = 0;

    immediate_gen dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ctrl(ctrl),
        .imm26(imm26), .out_valid(out_valid), .imm64(imm64), .illegal(illegal)
    );

    always #5 clk = ~clk;

`ifdef IMMGEN_BRSHIFT_EN
    localparam logic [63:0] EXP_B  = 64'hFFFF_FFFF_FE00_0054;
    localparam logic [63:0] EXP_CB = 64'hFFFF_FFFF_FFF0_0004;
`else
    localparam logic [63:0] EXP_B  = 64'hFFFF_FFFF_FF80_0015;
    localparam logic [63:0] EXP_CB = 64'hFFFF_FFFF_FFFC_0001;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [63:0] imm, input logic ill);
        chk({tag, ".valid"}, {63'd0, out_valid}, {63'd0, v});
        chk({tag, ".imm64"}, imm64, imm);
        chk({tag, ".illegal"}, {63'd0, illegal}, {63'd0, ill});
    endtask

    task automatic step(input logic v, input logic [2:0] c, input logic [25:0] i);
        in_valid = v;
        ctrl     = c;
        imm26    = i;
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  s_c [5];
    logic [25:0] s_i [5];
    logic [63:0] s_e [5];
    logic        s_l [5];

    initial begin
        // In-reset behaviour: in_valid is ignored
        in_valid = 1'b1; ctrl = 3'd0; imm26 = 26'h000AAAA;
        @(posedge clk); #1;
        chk_out("reset", 1'b0, 64'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 3'b000, 26'h000AAAA);
        chk_out("fmt_i", 1'b1, 64'h2A, 1'b0);
        step(1'b1, 3'b001, 26'h0101000);
        chk_out("fmt_d", 1'b1, 64'hFFFF_FFFF_FFFF_FF01, 1'b0);
        step(1'b1, 3'b100, 26'h0100020);
        chk_out("fmt_lw", 1'b1, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
        step(1'b1, 3'b010, 26'h3800015);
        chk_out("fmt_b", 1'b1, EXP_B, 1'b0);
        step(1'b1, 3'b011, 26'h1800038);
        chk_out("fmt_cb", 1'b1, EXP_CB, 1'b0);
        // Only out-of-field bits set: result must be zero
        step(1'b1, 3'b000, 26'h3C003FF);
        chk_out("i_outside", 1'b1, 64'd0, 1'b0);
        step(1'b1, 3'b001, 26'h3E00FFF);
        chk_out("d_outside", 1'b1, 64'd0, 1'b0);
        // D field positive max: no sign fill
        step(1'b1, 3'b001, 26'h00FF000);
        chk_out("d_pos", 1'b1, 64'hFF, 1'b0);
        step(1'b1, 3'b110, 26'h3FFFFFF);
        chk_out("ill_110", 1'b1, 64'd0, 1'b1);
        step(1'b1, 3'b111, 26'h1234567);
        chk_out("ill_111", 1'b1, 64'd0, 1'b1);
        step(1'b1, 3'b101, 26'h2AAAAAA);
        chk_out("ill_101", 1'b1, 64'd0, 1'b1);
        step(1'b0, 3'b000, 26'h000AAAA);
        chk_out("hold_ill", 1'b0, 64'd0, 1'b1);
        step(1'b1, 3'b100, 26'h0100020);
        step(1'b0, 3'b001, 26'h0101000);
        chk_out("hold_lw", 1'b0, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
        step(1'b0, 3'b001, 26'h0101000);
        chk_out("hold_lw2", 1'b0, 64'hFFFF_FFFF_FFFF_8001, 1'b0);

        // Asynchronous reset between edges while out_valid is high
        step(1'b1, 3'b010, 26'h3800015);
        chk_out("pre_rst", 1'b1, EXP_B, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 64'd0, 1'b0);
        @(posedge clk); #1;
        chk_out("rst_hold", 1'b0, 64'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back stream, one-cycle latency each
        s_c[0] = 3'b000; s_i[0] = 26'h000AAAA; s_e[0] = 64'h2A;                  s_l[0] = 1'b0;
        s_c[1] = 3'b011; s_i[1] = 26'h1800038; s_e[1] = EXP_CB;                  s_l[1] = 1'b0;
        s_c[2] = 3'b101; s_i[2] = 26'h0000001; s_e[2] = 64'd0;                   s_l[2] = 1'b1;
        s_c[3] = 3'b001; s_i[3] = 26'h0101000; s_e[3] = 64'hFFFF_FFFF_FFFF_FF01; s_l[3] = 1'b0;
        s_c[4] = 3'b010; s_i[4] = 26'h3800015; s_e[4] = EXP_B;                   s_l[4] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, s_c[k], s_i[k]);
            chk_out($sformatf("stream%0d", k), 1'b1, s_e[k], s_l[k]);
        end
        step(1'b0, 3'b000, 26'h0);
        chk_out("stream_end", 1'b0, EXP_B, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
